// File: rtl/l2_req_arb_pkg.sv
// l2_req_arb_pkg: shared constants and types
// for the L1-to-L2 request arbiter.
package l2_req_arb_pkg;

  localparam int L2REQ_ICACHE = 0;
  localparam int L2REQ_DCACHE = 1;
  localparam int L2REQ_NREQ   = 2;

  typedef enum logic {
    LK_IDLE,
    LK_LOCKED
  } lock_st_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l2_req_arb_fifo.sv
// l2_req_arb_fifo: small synchronous FIFO used
// as the in-order grant ID queue.
module l2_req_arb_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  // Storage array; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push)
        wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
      if (do_pop)
        rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
      if (do_push && !do_pop)
        cnt <= cnt + 1'b1;
      else if (!do_push && do_pop)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/l2_req_arb.sv
// l2_req_arb: round-robin share of the single L2
// port between L1 requesters, in-order response steering.
module l2_req_arb
  import l2_req_arb_pkg::*;
#(
  parameter int NREQ  = L2REQ_NREQ,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            rq_valid,
  input  logic [2*NREQ-1:0]          rq_op,
  input  logic [30*NREQ-1:0]         rq_addr,
  input  logic [4*NREQ-1:0]          rq_wmask,
  input  logic [32*NREQ-1:0]         rq_wdata,
  output logic [NREQ-1:0]            rq_ready,
  output logic                       req_valid,
  output logic [1:0]                 req_op,
  output logic [29:0]                req_addr,
  output logic [3:0]                 req_wmask,
  output logic [31:0]                req_wdata,
  input  logic                       l2_req_ready,
  input  logic                       l2_resp_valid,
  input  logic                       l2_resp_error,
  input  logic [63:0]                l2_resp_rdata,
  output logic                       resp_ready,
  output logic [NREQ-1:0]            rs_valid,
  output logic                       rs_error,
  output logic [63:0]                rs_rdata,
  input  logic [NREQ-1:0]            rs_ready,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       orphan_err
);

  localparam int IDW = clog2_min1(NREQ);

  lock_st_e        lk_q;
  lock_st_e        lk_d;
  logic [IDW-1:0]  lock_id;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  rr_nxt;
  logic [IDW-1:0]  gnt_rr;
  logic [IDW-1:0]  grant;
  logic [IDW-1:0]  head;
  logic [NREQ-1:0] elig;
  logic            any_elig;
  logic            locked;
  logic            q_full;
  logic            q_empty;
  logic            accept;
  logic            pop;
  logic            orphan;

  assign locked = (lk_q == LK_LOCKED);
  assign rr_nxt = (grant == IDW'(NREQ - 1)) ? '0
                                            : grant + 1'b1;

  // Round-robin pick: first eligible index from rr_ptr.
  always_comb begin
    elig     = rq_valid & {NREQ{~q_full}};
    any_elig = 1'b0;
    gnt_rr   = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!any_elig &&
          elig[(int'(rr_ptr) + k) % NREQ]) begin
        any_elig = 1'b1;
        gnt_rr   = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  // Request mux; a stalled request stays pinned by the lock.
  always_comb begin
    grant     = locked ? lock_id : gnt_rr;
    req_valid = !rst && (locked || any_elig);
    req_op    = rq_op[2*int'(grant) +: 2];
    req_addr  = rq_addr[30*int'(grant) +: 30];
    req_wmask = rq_wmask[4*int'(grant) +: 4];
    req_wdata = rq_wdata[32*int'(grant) +: 32];
    accept    = req_valid && l2_req_ready;
    rq_ready  = '0;
    if (accept) rq_ready[grant] = 1'b1;
  end

  // Response steering; orphans are drained unclaimed.
  always_comb begin
    rs_error   = l2_resp_error;
    rs_rdata   = l2_resp_rdata;
    orphan     = !rst && l2_resp_valid && q_empty;
    resp_ready = !rst && (q_empty ? l2_resp_valid
                                  : rs_ready[head]);
    rs_valid   = '0;
    if (!rst && l2_resp_valid && !q_empty)
      rs_valid[head] = 1'b1;
    pop = l2_resp_valid && resp_ready && !q_empty;
  end

  // Lock next state: hold grant while L2 stalls.
  always_comb begin
    lk_d = lk_q;
    unique case (lk_q)
      LK_IDLE:   if (req_valid && !l2_req_ready)
                   lk_d = LK_LOCKED;
      LK_LOCKED: if (l2_req_ready)
                   lk_d = LK_IDLE;
    endcase
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) lk_q <= LK_IDLE;
    else     lk_q <= lk_d;
  end

  // Lock id, rr pointer, occupancy and sticky orphan flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_id     <= '0;
      rr_ptr      <= IDW'(L2REQ_ICACHE);
      outstanding <= '0;
      orphan_err  <= 1'b0;
    end else begin
      if (!locked && lk_d == LK_LOCKED)
        lock_id <= grant;
      if (accept)
        rr_ptr <= rr_nxt;
      if (accept && !pop)
        outstanding <= outstanding + 1'b1;
      else if (!accept && pop)
        outstanding <= outstanding - 1'b1;
      if (orphan)
        orphan_err <= 1'b1;
    end
  end

  l2_req_arb_fifo #(
    .W     (IDW),
    .DEPTH (DEPTH)
  ) u_idq (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (grant),
    .pop   (pop),
    .rdata (head),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_l2_req_arb.sv
// tb_l2_req_arb: directed table and sequence checks
// for the L2 request arbiter (NREQ=2, DEPTH=4).
module tb_l2_req_arb;

  logic        clk;
  logic        rst;
  logic [1:0]  rq_valid;
  logic [3:0]  rq_op;
  logic [59:0] rq_addr;
  logic [7:0]  rq_wmask;
  logic [63:0] rq_wdata;
  logic [1:0]  rq_ready;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [29:0] req_addr;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic        l2_req_ready;
  logic        l2_resp_valid;
  logic        l2_resp_error;
  logic [63:0] l2_resp_rdata;
  logic        resp_ready;
  logic [1:0]  rs_valid;
  logic        rs_error;
  logic [63:0] rs_rdata;
  logic [1:0]  rs_ready;
  logic [2:0]  outstanding;
  logic        orphan_err;

  int n_run  = 0;
  int n_fail = 0;

  localparam logic [29:0] A0 = 30'h400;
  localparam logic [29:0] A1 = 30'h800;
  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'h2222_2222;

  l2_req_arb #(.NREQ(2), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .rq_valid      (rq_valid),
    .rq_op         (rq_op),
    .rq_addr       (rq_addr),
    .rq_wmask      (rq_wmask),
    .rq_wdata      (rq_wdata),
    .rq_ready      (rq_ready),
    .req_valid     (req_valid),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wmask     (req_wmask),
    .req_wdata     (req_wdata),
    .l2_req_ready  (l2_req_ready),
    .l2_resp_valid (l2_resp_valid),
    .l2_resp_error (l2_resp_error),
    .l2_resp_rdata (l2_resp_rdata),
    .resp_ready    (resp_ready),
    .rs_valid      (rs_valid),
    .rs_error      (rs_error),
    .rs_rdata      (rs_rdata),
    .rs_ready      (rs_ready),
    .outstanding   (outstanding),
    .orphan_err    (orphan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic        rdy;
    logic        rv;
    logic [63:0] rd;
    logic [1:0]  rsr;
    logic [1:0]  e_rqr;
    logic        e_rqv;
    logic [29:0] e_addr;
    logic [1:0]  e_rsv;
    logic        e_rspr;
    logic [2:0]  e_out;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rq_valid      = 2'b00;
    l2_req_ready  = 1'b0;
    l2_resp_valid = 1'b0;
    l2_resp_error = 1'b0;
    l2_resp_rdata = 64'h0;
    rs_ready      = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rq_op    = {2'b10, 2'b01};
    rq_addr  = {A1, A0};
    rq_wmask = {4'hF, 4'h3};
    rq_wdata = {W1, W0};

    tv[0] = '{2'b11, 1'b1, 1'b0, 64'h0, 2'b00,
              2'b01, 1'b1, A0, 2'b00, 1'b0, 3'd0};
    tv[1] = '{2'b11, 1'b1, 1'b0, 64'h0, 2'b00,
              2'b10, 1'b1, A1, 2'b00, 1'b0, 3'd1};
    tv[2] = '{2'b11, 1'b1, 1'b0, 64'h0, 2'b00,
              2'b01, 1'b1, A0, 2'b00, 1'b0, 3'd2};
    tv[3] = '{2'b11, 1'b1, 1'b0, 64'h0, 2'b00,
              2'b10, 1'b1, A1, 2'b00, 1'b0, 3'd3};
    tv[4] = '{2'b00, 1'b1, 1'b1, 64'hA1, 2'b11,
              2'b00, 1'b0, A0, 2'b01, 1'b1, 3'd4};
    tv[5] = '{2'b00, 1'b1, 1'b1, 64'hB2, 2'b11,
              2'b00, 1'b0, A0, 2'b10, 1'b1, 3'd3};
    tv[6] = '{2'b00, 1'b1, 1'b1, 64'hC3, 2'b11,
              2'b00, 1'b0, A0, 2'b01, 1'b1, 3'd2};
    tv[7] = '{2'b00, 1'b1, 1'b1, 64'hD4, 2'b11,
              2'b00, 1'b0, A0, 2'b10, 1'b1, 3'd1};

    // reset cycle with busy inputs: outputs gated
    rst           = 1'b1;
    rq_valid      = 2'b11;
    l2_req_ready  = 1'b1;
    l2_resp_valid = 1'b1;
    l2_resp_error = 1'b0;
    l2_resp_rdata = 64'h0;
    rs_ready      = 2'b11;
    #2;
    chk("rst rq_ready", 64'(rq_ready), 0);
    chk("rst req_valid", 64'(req_valid), 0);
    chk("rst resp_ready", 64'(resp_ready), 0);
    chk("rst rs_valid", 64'(rs_valid), 0);
    step();
    rst = 1'b0;
    clr();
    #1;
    chk("rst outstanding", 64'(outstanding), 0);
    chk("rst orphan_err", 64'(orphan_err), 0);

    // 1: alternating grants, in-order responses
    for (int i = 0; i < 8; i++) begin
      rq_valid      = tv[i].v;
      l2_req_ready  = tv[i].rdy;
      l2_resp_valid = tv[i].rv;
      l2_resp_rdata = tv[i].rd;
      rs_ready      = tv[i].rsr;
      #1;
      chk($sformatf("t1[%0d] rq_ready", i),
          64'(rq_ready), 64'(tv[i].e_rqr));
      chk($sformatf("t1[%0d] req_valid", i),
          64'(req_valid), 64'(tv[i].e_rqv));
      if (tv[i].e_rqv)
        chk($sformatf("t1[%0d] req_addr", i),
            64'(req_addr), 64'(tv[i].e_addr));
      chk($sformatf("t1[%0d] rs_valid", i),
          64'(rs_valid), 64'(tv[i].e_rsv));
      chk($sformatf("t1[%0d] resp_ready", i),
          64'(resp_ready), 64'(tv[i].e_rspr));
      chk($sformatf("t1[%0d] outstanding", i),
          64'(outstanding), 64'(tv[i].e_out));
      if (tv[i].rv)
        chk($sformatf("t1[%0d] rs_rdata", i),
            rs_rdata, tv[i].rd);
      step();
    end
    clr();
    #1;
    chk("t1 drained", 64'(outstanding), 0);

    // 2: stall holds request and grant
    do_reset();
    rq_valid = 2'b01;
    #1;
    chk("t2 c1 req_valid", 64'(req_valid), 1);
    chk("t2 c1 addr", 64'(req_addr), 64'(A0));
    chk("t2 c1 rq_ready", 64'(rq_ready), 0);
    step();
    rq_valid = 2'b11;
    #1;
    chk("t2 c2 addr", 64'(req_addr), 64'(A0));
    chk("t2 c2 op", 64'(req_op), 1);
    chk("t2 c2 rq_ready", 64'(rq_ready), 0);
    step();
    #1;
    chk("t2 c3 addr", 64'(req_addr), 64'(A0));
    step();
    l2_req_ready = 1'b1;
    #1;
    chk("t2 acc0 rq_ready", 64'(rq_ready), 1);
    chk("t2 acc0 wmask", 64'(req_wmask), 3);
    step();
    rq_valid = 2'b10;
    #1;
    chk("t2 acc1 rq_ready", 64'(rq_ready), 2);
    chk("t2 acc1 addr", 64'(req_addr), 64'(A1));
    chk("t2 acc1 wdata", 64'(req_wdata), 64'(W1));
    step();
    // lock on 1 while rr_ptr points at 0
    l2_req_ready = 1'b0;
    #1;
    chk("t2 lk1 addr", 64'(req_addr), 64'(A1));
    step();
    rq_valid = 2'b11;
    #1;
    chk("t2 lk2 addr", 64'(req_addr), 64'(A1));
    chk("t2 lk2 rq_ready", 64'(rq_ready), 0);
    step();
    l2_req_ready = 1'b1;
    #1;
    chk("t2 lk3 rq_ready", 64'(rq_ready), 2);
    step();
    clr();
    #1;
    chk("t2 outstanding", 64'(outstanding), 3);

    // 3: full queue blocks, no bypass on pop
    do_reset();
    rq_valid     = 2'b01;
    l2_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t3 fill%0d rq_ready", i),
          64'(rq_ready), 1);
      step();
    end
    #1;
    chk("t3 full req_valid", 64'(req_valid), 0);
    chk("t3 full rq_ready", 64'(rq_ready), 0);
    chk("t3 full outstanding", 64'(outstanding), 4);
    step();
    l2_resp_valid = 1'b1;
    l2_resp_rdata = 64'h55;
    rs_ready      = 2'b01;
    #1;
    chk("t3 pop rs_valid", 64'(rs_valid), 1);
    chk("t3 pop resp_ready", 64'(resp_ready), 1);
    chk("t3 pop req_valid", 64'(req_valid), 0);
    step();
    l2_resp_valid = 1'b0;
    #1;
    chk("t3 after req_valid", 64'(req_valid), 1);
    chk("t3 after rq_ready", 64'(rq_ready), 1);
    chk("t3 after outstanding", 64'(outstanding), 3);
    step();
    clr();
    #1;
    chk("t3 refill outstanding", 64'(outstanding), 4);

    // 4: backpressured response to requester 1
    do_reset();
    rq_valid     = 2'b10;
    l2_req_ready = 1'b1;
    #1;
    chk("t4 acc rq_ready", 64'(rq_ready), 2);
    step();
    clr();
    l2_resp_valid = 1'b1;
    l2_resp_error = 1'b1;
    l2_resp_rdata = 64'hDEAD_BEEF_0123_4567;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("t4 hold%0d rs_valid", i),
          64'(rs_valid), 2);
      chk($sformatf("t4 hold%0d resp_ready", i),
          64'(resp_ready), 0);
      chk($sformatf("t4 hold%0d rdata", i),
          rs_rdata, 64'hDEAD_BEEF_0123_4567);
      chk($sformatf("t4 hold%0d outstanding", i),
          64'(outstanding), 1);
      step();
    end
    rs_ready = 2'b10;
    #1;
    chk("t4 go resp_ready", 64'(resp_ready), 1);
    chk("t4 go rs_error", 64'(rs_error), 1);
    step();
    clr();
    #1;
    chk("t4 outstanding", 64'(outstanding), 0);

    // 5: orphan response
    do_reset();
    l2_resp_valid = 1'b1;
    #1;
    chk("t5 resp_ready", 64'(resp_ready), 1);
    chk("t5 rs_valid", 64'(rs_valid), 0);
    chk("t5 orphan pre", 64'(orphan_err), 0);
    step();
    l2_resp_valid = 1'b0;
    #1;
    chk("t5 orphan set", 64'(orphan_err), 1);
    step();
    step();
    chk("t5 orphan sticky", 64'(orphan_err), 1);
    chk("t5 idle resp_ready", 64'(resp_ready), 0);

    // 6: reset with 3 outstanding and a held lock
    do_reset();
    rq_valid     = 2'b11;
    l2_req_ready = 1'b1;
    step();
    step();
    step();
    l2_req_ready = 1'b0;
    #1;
    chk("t6 pre outstanding", 64'(outstanding), 3);
    chk("t6 pre addr", 64'(req_addr), 64'(A1));
    step();
    rst           = 1'b1;
    l2_req_ready  = 1'b1;
    l2_resp_valid = 1'b1;
    rs_ready      = 2'b11;
    #1;
    chk("t6 rst rq_ready", 64'(rq_ready), 0);
    chk("t6 rst req_valid", 64'(req_valid), 0);
    chk("t6 rst resp_ready", 64'(resp_ready), 0);
    step();
    rst           = 1'b0;
    l2_req_ready  = 1'b0;
    l2_resp_valid = 1'b0;
    #1;
    chk("t6 outstanding", 64'(outstanding), 0);
    chk("t6 rq_ready", 64'(rq_ready), 0);
    chk("t6 addr", 64'(req_addr), 64'(A0));
    chk("t6 orphan", 64'(orphan_err), 0);
    step();
    l2_req_ready = 1'b1;
    #1;
    chk("t6 grant0", 64'(rq_ready), 1);
    step();
    clr();

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
